// File: rtl/fp_fifo_pkg.sv
// Shared types and helpers for the FP operand FIFO.
// Holds the FP32 operand type, the operand-pair struct, the FIFO state encoding
// and the operand classifier used when FP_CLASSIFY_EN is defined.
package fp_fifo_pkg;

    typedef logic [31:0] fp32_t;

    typedef struct packed {
        fp32_t a;
        fp32_t b;
    } fp_pair_t;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } fifo_state_t;

    // Exponent field position inside an IEEE-754 single-precision word.
    localparam int FP_EXP_MSB = 30;
    localparam int FP_EXP_LSB = 23;

    // An operand is special when its exponent is all ones (Inf/NaN)
    // or all zeros (zero/denormal).
    function automatic logic is_special(input fp32_t op);
        logic [7:0] exp_s;
        exp_s = op[FP_EXP_MSB:FP_EXP_LSB];
        return (exp_s == 8'hFF) || (exp_s == 8'h00);
    endfunction

endpackage

// File: rtl/fp_fifo_mem.sv
// Operand storage for the FP operand FIFO.
// DEPTH entries of EW bits, one synchronous write port and one
// combinational (fall-through) read port. Contents are not reset.
module fp_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int EW    = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [EW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [EW-1:0] rdata
);

    logic [EW-1:0] mem_r [DEPTH];

    // Write the incoming entry on an accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fp_operand_fifo.sv
// Elastic buffer for FP32 operand pairs in front of the multiplier wrapper.
// Source side and multiplier side each use a valid/ready handshake; the head
// pair falls through combinationally from storage. IN_READY and OUT_VALID are
// registers updated from the next-state entry count, so neither depends
// combinationally on IN_VALID or OUT_READY.
// Optional feature macro: FP_CLASSIFY_EN adds a per-entry "special operand"
// flag and the OUT_SPECIAL output.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fp_operand_fifo
    import fp_fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       CLK,
    input  logic                       RST_n,
    input  logic [WIDTH-1:0]           IN_A,
    input  logic [WIDTH-1:0]           IN_B,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    output logic [WIDTH-1:0]           OUT_A,
    output logic [WIDTH-1:0]           OUT_B,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [$clog2(DEPTH):0]     COUNT
`ifdef FP_CLASSIFY_EN
    ,
    output logic                       OUT_SPECIAL
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef FP_CLASSIFY_EN
    localparam int EW = 2 * WIDTH + 1;
`else
    localparam int EW = 2 * WIDTH;
`endif

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    fifo_state_t   state_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          in_ready_r;
    logic          out_valid_r;
    logic          push_s;
    logic          pop_s;
    logic [EW-1:0] wr_entry_s;
    logic [EW-1:0] rd_entry_s;

    // Handshake qualification and next entry count.
    always_comb begin
        push_s       = IN_VALID & in_ready_r;
        pop_s        = out_valid_r & OUT_READY;
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (!push_s && pop_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Pack the incoming pair (and its classification flag) into one entry.
    always_comb begin
`ifdef FP_CLASSIFY_EN
        wr_entry_s = {IN_A, IN_B,
                      is_special(fp32_t'(IN_A)) | is_special(fp32_t'(IN_B))};
`else
        wr_entry_s = {IN_A, IN_B};
`endif
    end

    // Write and read pointers; both wrap modulo DEPTH.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Occupancy counter.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_next_s;
        end
    end

    // Control FSM with registered handshake outputs. INIT lasts one cycle
    // after reset release so the source sees IN_READY only once RUN is stable.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_r     <= INIT;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    state_r     <= RUN;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
                RUN: begin
                    state_r     <= RUN;
                    in_ready_r  <= (count_next_s != CNT_FULL);
                    out_valid_r <= (count_next_s != CNT_ZERO);
                end
                default: begin
                    state_r     <= INIT;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    fp_fifo_mem #(
        .DEPTH (DEPTH),
        .EW    (EW),
        .AW    (AW)
    ) u_mem (
        .clk   (CLK),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (wr_entry_s),
        .raddr (rd_ptr_r),
        .rdata (rd_entry_s)
    );

    assign IN_READY  = in_ready_r;
    assign OUT_VALID = out_valid_r;
    assign COUNT     = count_r;
    assign OUT_A     = rd_entry_s[EW-1 -: WIDTH];
    assign OUT_B     = rd_entry_s[EW-1-WIDTH -: WIDTH];
`ifdef FP_CLASSIFY_EN
    // The stored flag is only meaningful while a pair is presented.
    assign OUT_SPECIAL = rd_entry_s[0] & out_valid_r;
`endif

endmodule

// File: tb/tb_fp_operand_fifo.sv
// Scoreboard bench for fp_operand_fifo: stimulus tasks push expected pairs at
// the accepting handshake, an independent negedge monitor pops and compares
// whenever the FIFO hands a pair to the consumer, and checks hold stability.
module tb_fp_operand_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              CLK;
    logic              RST_n;
    logic [WIDTH-1:0]  IN_A;
    logic [WIDTH-1:0]  IN_B;
    logic              IN_VALID;
    logic              IN_READY;
    logic [WIDTH-1:0]  OUT_A;
    logic [WIDTH-1:0]  OUT_B;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [CW-1:0]     COUNT;
`ifdef FP_CLASSIFY_EN
    logic              OUT_SPECIAL;
`endif

    fp_operand_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .IN_A      (IN_A),
        .IN_B      (IN_B),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OUT_A     (OUT_A),
        .OUT_B     (OUT_B),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .COUNT     (COUNT)
`ifdef FP_CLASSIFY_EN
        ,
        .OUT_SPECIAL (OUT_SPECIAL)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [63:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Offer one pair until accepted; records it in the scoreboard at the
    // accepting edge. Returns the number of cycles spent waiting.
    task automatic send(input logic [31:0] a, input logic [31:0] b, output int waits);
        logic accepted;
        accepted = 1'b0;
        waits    = 0;
        IN_A     = a;
        IN_B     = b;
        IN_VALID = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge CLK);
            if (IN_READY === 1'b1) begin
                exp_q.push_back({a, b});
                accepted = 1'b1;
            end
            @(posedge CLK);
            #1;
            if (accepted) break;
            waits++;
        end
        IN_VALID = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted");
        end
    endtask

    // Consume everything stored, bounded.
    task automatic drain(input string name);
        OUT_READY = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(posedge CLK);
            #1;
            if (COUNT == '0) break;
        end
        OUT_READY = 1'b0;
        chk({name, "_count"}, 64'(COUNT), 64'd0);
        chk({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compare each consumed pair, check data hold while stalled.
    logic        stall_prev = 1'b0;
    logic [63:0] stall_data = 64'd0;
    always @(negedge CLK) begin
        if (RST_n !== 1'b1) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 64'(OUT_VALID), 64'd1);
                chk("stall_data", {OUT_A, OUT_B}, stall_data);
            end
            if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out actual=%h_%h required=no_pair", OUT_A, OUT_B);
                end else begin
                    chk("out_pair", {OUT_A, OUT_B}, exp_q.pop_front());
                end
            end
            stall_prev <= (OUT_VALID === 1'b1) && (OUT_READY !== 1'b1);
            stall_data <= {OUT_A, OUT_B};
        end
    end

    initial begin
        int w;
        int sent;
        int cyc;
        logic [31:0] cur_a;
        logic [31:0] cur_b;

        RST_n     = 1'b0;
        IN_A      = 32'd0;
        IN_B      = 32'd0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;

        // 1. Reset / INIT
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_in_ready", 64'(IN_READY), 64'd0);
        chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_count", 64'(COUNT), 64'd0);
        RST_n = 1'b1;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        chk("init_in_ready_2nd_edge", 64'(IN_READY), 64'd1);
        chk("init_out_valid", 64'(OUT_VALID), 64'd0);

        // 2. Single pass: 1.5 x 2.0
        send(32'h3FC00000, 32'h40000000, w);
        chk("single_valid", 64'(OUT_VALID), 64'd1);
        chk("single_a", 64'(OUT_A), 64'h3FC00000);
        chk("single_b", 64'(OUT_B), 64'h40000000);
        chk("single_count", 64'(COUNT), 64'd1);
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        chk("single_count_after_pop", 64'(COUNT), 64'd0);
        chk("single_valid_after_pop", 64'(OUT_VALID), 64'd0);

        // 3. Fill to full, then a held 9th pair during a pop
        for (int i = 0; i < DEPTH; i++) begin
            send(32'(i), ~32'(i), w);
        end
        chk("full_in_ready", 64'(IN_READY), 64'd0);
        chk("full_count", 64'(COUNT), 64'd8);
        IN_A      = 32'd8;
        IN_B      = ~32'd8;
        IN_VALID  = 1'b1;
        OUT_READY = 1'b1;
        @(negedge CLK);
        chk("full_pop_no_accept", 64'(IN_READY), 64'd0);
        @(posedge CLK);
        #1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        chk("full_pop_count", 64'(COUNT), 64'd7);
        send(32'd8, ~32'd8, w);
        chk("refill_count", 64'(COUNT), 64'd8);
        drain("fill_drain");

        // 4. Throughput and pointer wrap
        OUT_READY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(32'h100 + 32'(i), 32'hA5A50000 ^ 32'(i), w);
            chk("tput_waits", 64'(w), 64'd0);
            chk("tput_count", 64'(COUNT), 64'd1);
        end
        drain("tput_drain");

        // 5. Random valid / ready over 1000 pairs
        sent  = 0;
        cyc   = 0;
        cur_a = $urandom;
        cur_b = $urandom;
        while (sent < 1000 && cyc < 20000) begin
            IN_A      = cur_a;
            IN_B      = cur_b;
            IN_VALID  = 1'($urandom_range(0, 1));
            OUT_READY = 1'($urandom_range(0, 1));
            @(negedge CLK);
            if (IN_VALID && IN_READY === 1'b1) begin
                exp_q.push_back({cur_a, cur_b});
                sent++;
                cur_a = $urandom;
                cur_b = $urandom;
            end
            @(posedge CLK);
            #1;
            cyc++;
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        chk("rand_sent", 64'(sent), 64'd1000);
        drain("rand_drain");

        // 6. Mid-operation flush
        for (int i = 0; i < 5; i++) begin
            send(32'h55 + 32'(i), 32'hAA + 32'(i), w);
        end
        chk("flush_pre_count", 64'(COUNT), 64'd5);
        RST_n = 1'b0;
        @(posedge CLK);
        #1;
        exp_q.delete();
        chk("flush_count", 64'(COUNT), 64'd0);
        chk("flush_out_valid", 64'(OUT_VALID), 64'd0);
        chk("flush_in_ready", 64'(IN_READY), 64'd0);
        RST_n = 1'b1;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        chk("flush_recover_in_ready", 64'(IN_READY), 64'd1);
        chk("flush_recover_out_valid", 64'(OUT_VALID), 64'd0);

`ifdef FP_CLASSIFY_EN
        chk("special_empty", 64'(OUT_SPECIAL), 64'd0);
        send(32'h7F800000, 32'h40000000, w);
        chk("special_inf", 64'(OUT_SPECIAL), 64'd1);
        drain("special_inf_drain");
        send(32'h3FC00000, 32'h40000000, w);
        chk("special_normal", 64'(OUT_SPECIAL), 64'd0);
        drain("special_normal_drain");
        send(32'h3FC00000, 32'h00000000, w);
        chk("special_zero_b", 64'(OUT_SPECIAL), 64'd1);
        drain("special_zero_drain");
`endif

        send(32'hC0490FDB, 32'h3F800000, w);
        drain("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
